// File: rtl/skew_stream_buffer.sv
// Double-buffered operand skewer for the systolic array edge: captures a tile of rows into one
// of two banks and replays it with lane l delayed by l*SKEW_STEP beats, zero-filled outside each window.
module skew_stream_buffer #(
  parameter int BITS      = 8,
  parameter int LANES     = 8,
  parameter int MAX_LEN   = 16,
  parameter int SKEW_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*BITS-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*BITS-1:0] out_data,
  output logic [LANES-1:0]      out_lane_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int SKEW_SPAN = (LANES - 1) * SKEW_STEP;
  localparam int T_W       = $clog2(MAX_LEN + SKEW_SPAN + 1);
  localparam int PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MEM_D     = 1 << PTR_W;

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [BITS-1:0]         mem_r [2][MEM_D][LANES];
  logic [T_W-1:0]          len_r [2];
  logic [1:0]              full_r;
  logic                    wr_bank_r, rd_bank_r, rd_bank_s, sel_bank_s;
  logic [T_W-1:0]          wr_ptr_r, t_r, t_s, sel_t_s, beats_s;
  logic                    load_s, clear_s, release_s, done_s;
  logic                    in_fire_s, in_end_s, out_fire_s, last_beat_s;
  logic [LANES*BITS-1:0]   beat_data_s;
  logic [LANES-1:0]        beat_lv_s;

  assign in_ready    = !full_r[wr_bank_r];
  assign in_fire_s   = in_valid && in_ready;
  assign in_end_s    = in_last || (wr_ptr_r == T_W'(MAX_LEN - 1));
  assign out_valid   = (state_r == STREAM);
  assign busy        = (state_r == STREAM);
  assign out_fire_s  = out_valid && out_ready;
  assign beats_s     = len_r[rd_bank_r] + T_W'(SKEW_SPAN);
  assign last_beat_s = out_fire_s && (t_r == beats_s - T_W'(1));

  // Write pointer, bank lengths and full flags; the reader only ever clears the bank it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_r <= 1'b0;
      wr_ptr_r  <= '0;
      full_r    <= 2'b00;
      len_r[0]  <= '0;
      len_r[1]  <= '0;
    end else begin
      if (in_fire_s) begin
        if (in_end_s) begin
          len_r[wr_bank_r]  <= wr_ptr_r + T_W'(1);
          full_r[wr_bank_r] <= 1'b1;
          wr_bank_r         <= ~wr_bank_r;
          wr_ptr_r          <= '0;
        end else begin
          wr_ptr_r <= wr_ptr_r + T_W'(1);
        end
      end
      if (release_s) begin
        full_r[rd_bank_r] <= 1'b0;
      end
    end
  end

  // Tile storage, written one row per accepted input beat.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      for (int l = 0; l < LANES; l++) begin
        mem_r[wr_bank_r][wr_ptr_r[PTR_W-1:0]][l] <= in_data[l*BITS +: BITS];
      end
    end
  end

  // Skewed beat for (sel_bank_s, sel_t_s): lane g shows row t - g*SKEW_STEP when that row exists.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam logic signed [T_W:0] OFF = (T_W + 1)'(g * SKEW_STEP);
    logic signed [T_W:0] idx_s;
    assign idx_s = $signed({1'b0, sel_t_s}) - OFF;
    assign beat_lv_s[g] = !idx_s[T_W] && (idx_s < $signed({1'b0, len_r[sel_bank_s]}));
    assign beat_data_s[g*BITS +: BITS] = beat_lv_s[g] ? mem_r[sel_bank_s][idx_s[PTR_W-1:0]][g]
                                                      : {BITS{1'b0}};
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Read FSM next state; the final beat chains straight into the other bank when it is ready.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (full_r[rd_bank_r]) state_s = STREAM;
        else                   state_s = IDLE;
      end
      STREAM: begin
        if (last_beat_s) state_s = full_r[~rd_bank_r] ? STREAM : IDLE;
        else             state_s = STREAM;
      end
      default: state_s = IDLE;
    endcase
  end

  // Read FSM outputs: which beat to load into the output register, and bank hand-back.
  always_comb begin
    load_s     = 1'b0;
    clear_s    = 1'b0;
    release_s  = 1'b0;
    done_s     = 1'b0;
    sel_bank_s = rd_bank_r;
    sel_t_s    = '0;
    t_s        = t_r;
    rd_bank_s  = rd_bank_r;
    case (state_r)
      IDLE: begin
        if (full_r[rd_bank_r]) begin
          load_s = 1'b1;
          t_s    = '0;
        end else begin
          t_s = t_r;
        end
      end
      STREAM: begin
        if (last_beat_s) begin
          release_s = 1'b1;
          done_s    = 1'b1;
          rd_bank_s = ~rd_bank_r;
          t_s       = '0;
          if (full_r[~rd_bank_r]) begin
            load_s     = 1'b1;
            sel_bank_s = ~rd_bank_r;
          end else begin
            clear_s = 1'b1;
          end
        end else if (out_fire_s) begin
          load_s  = 1'b1;
          t_s     = t_r + T_W'(1);
          sel_t_s = t_r + T_W'(1);
        end else begin
          t_s = t_r;
        end
      end
      default: clear_s = 1'b1;
    endcase
  end

  // Registered beat outputs, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r            <= '0;
      rd_bank_r      <= 1'b0;
      done           <= 1'b0;
      out_data       <= '0;
      out_lane_valid <= '0;
    end else begin
      t_r       <= t_s;
      rd_bank_r <= rd_bank_s;
      done      <= done_s;
      if (load_s) begin
        out_data       <= beat_data_s;
        out_lane_valid <= beat_lv_s;
      end else if (clear_s) begin
        out_data       <= '0;
        out_lane_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_skew_stream_buffer.sv
// Directed bench for skew_stream_buffer: three builds (SKEW_STEP 1, 0, 2) share stimulus;
// the selected one is checked against a lane-skew reference model.
module tb_skew_stream_buffer;
  localparam int BITS = 8;
  localparam int LANES = 8;
  localparam int W = BITS * LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [2:0] in_ready_v, out_valid_v, busy_v, done_v;
  logic [2:0][W-1:0] out_data_v;
  logic [2:0][LANES-1:0] olv_v;
  logic [1:0] dsel = 2'd0;
  logic s_in_ready, s_out_valid, s_busy, s_done;
  logic [W-1:0] s_out_data;
  logic [LANES-1:0] s_olv;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    skew_stream_buffer #(.BITS(BITS), .LANES(LANES), .MAX_LEN(16),
                         .SKEW_STEP(g == 0 ? 1 : (g == 1 ? 0 : 2))) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[g]),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_v[g]), .out_ready(out_ready),
      .out_data(out_data_v[g]), .out_lane_valid(olv_v[g]), .busy(busy_v[g]), .done(done_v[g]));
  end

  always_comb begin
    case (dsel)
      2'd1:    begin s_in_ready = in_ready_v[1]; s_out_valid = out_valid_v[1]; s_busy = busy_v[1];
                     s_done = done_v[1]; s_out_data = out_data_v[1]; s_olv = olv_v[1]; end
      2'd2:    begin s_in_ready = in_ready_v[2]; s_out_valid = out_valid_v[2]; s_busy = busy_v[2];
                     s_done = done_v[2]; s_out_data = out_data_v[2]; s_olv = olv_v[2]; end
      default: begin s_in_ready = in_ready_v[0]; s_out_valid = out_valid_v[0]; s_busy = busy_v[0];
                     s_done = done_v[0]; s_out_data = out_data_v[0]; s_olv = olv_v[0]; end
    endcase
  end

  typedef struct {
    int dut;
    int len;
    int base;
    bit use_last;
    int pattern;
    int beats;
  } vec_t;

  vec_t tbl[6];

  function automatic int skew_of(input int dut);
    return (dut == 0) ? 1 : ((dut == 1) ? 0 : 2);
  endfunction

  function automatic logic [7:0] elem(input int base, input int r, input int l);
    return 8'((base + 16 * r + l) & 255);
  endfunction

  // Reference: lane l at beat t carries row t - l*s when that row exists, else 0.
  function automatic logic [W+LANES-1:0] exp_beat(input int len, input int base, input int s, input int t);
    logic [W-1:0] d;
    logic [LANES-1:0] lv;
    int idx;
    d = '0;
    lv = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = t - l * s;
      if (idx >= 0 && idx < len) begin
        d[l*BITS +: BITS] = elem(base, idx, l);
        lv[l] = 1'b1;
      end
    end
    return {d, lv};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = {LANES{8'hA5}};
  endtask

  task automatic send_tile(input int len, input int base, input bit use_last);
    int w;
    for (int r = 0; r < len; r++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last = use_last && (r == len - 1);
      for (int l = 0; l < LANES; l++) in_data[l*BITS +: BITS] = elem(base, r, l);
      w = 0;
      while (!s_in_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("in_ready row%0d", r), 128'(s_in_ready), 128'(1));
      @(posedge clk);
    end
  endtask

  task automatic recv_tile(input int len, input int base, input int s, input int pattern,
                           input int beats, input bit chk_lat, input bit expect_more,
                           output int first_l7);
    int t, cyc;
    bit first, rdy;
    t = 0;
    cyc = 0;
    first = 1'b1;
    first_l7 = -1;
    while (t < beats && cyc < 300) begin
      @(negedge clk);
      cyc++;
      rdy = (pattern == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
      if (s_out_valid) begin
        if (first && chk_lat) check("latency", 128'(cyc), 128'(1));
        first = 1'b0;
        check($sformatf("beat d%0d t%0d", dsel, t), {s_out_data, s_olv, s_busy, s_done},
              {exp_beat(len, base, s, t), 1'b1, 1'b0});
        if (s_olv[7] && first_l7 < 0) first_l7 = t;
        if (rdy) t++;
      end else begin
        check("idle busy/done", {s_busy, s_done}, 2'b00);
      end
      out_ready = rdy;
    end
    check("beat_count", 128'(t), 128'(beats));
    @(negedge clk);
    out_ready = 1'b0;
    check("done_pulse", {s_done, s_out_valid, s_busy}, {1'b1, expect_more, expect_more});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f7, w;
    tbl[0] = '{0, 8, 0, 1'b1, 0, 15};
    tbl[1] = '{0, 8, 0, 1'b1, 1, 15};
    tbl[2] = '{0, 1, 8'h55, 1'b1, 0, 8};
    tbl[3] = '{0, 16, 3, 1'b0, 0, 23};
    tbl[4] = '{1, 3, 8'h20, 1'b1, 1, 3};
    tbl[5] = '{2, 4, 8'h30, 1'b1, 0, 18};

    @(negedge clk);
    check("reset_state", {s_out_valid, s_out_data, s_olv, s_busy, s_done, s_in_ready},
          {1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < 6; i++) begin
      do_reset();
      dsel = 2'(tbl[i].dut);
      send_tile(tbl[i].len, tbl[i].base, tbl[i].use_last);
      idle_in();
      check("pre_latency", 128'(s_out_valid), 128'(0));
      recv_tile(tbl[i].len, tbl[i].base, skew_of(tbl[i].dut), tbl[i].pattern, tbl[i].beats,
                1'b1, 1'b0, f7);
      if (tbl[i].dut == 2) check("lane7_first", 128'(f7), 128'(14));
    end

    // Back-to-back tiles A, B, then C which must wait for A's bank.
    do_reset();
    dsel = 2'd0;
    fork
      begin
        send_tile(4, 8'h00, 1'b1);
        send_tile(6, 8'h08, 1'b1);
        idle_in();
        check("third_blocked", {s_in_ready, s_busy}, 2'b01);
        w = 0;
        while (!s_in_ready && w < 100) begin
          @(negedge clk);
          w++;
        end
        check("free_with_done", {s_in_ready, s_done}, 2'b11);
        send_tile(2, 8'h60, 1'b1);
        idle_in();
      end
      begin
        int fa;
        recv_tile(4, 8'h00, 1, 0, 11, 1'b0, 1'b1, fa);
        recv_tile(6, 8'h08, 1, 0, 13, 1'b0, 1'b1, fa);
        recv_tile(2, 8'h60, 1, 0, 9, 1'b0, 1'b0, fa);
      end
    join

    // Reset mid-stream with a partial second tile pending.
    do_reset();
    dsel = 2'd0;
    send_tile(8, 8'h10, 1'b1);
    send_tile(2, 8'h70, 1'b0);
    idle_in();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("midstream", {s_out_valid, s_busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {s_out_valid, s_out_data, s_olv, s_busy, s_done, s_in_ready},
          {1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b1});
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", {s_done, s_out_valid}, 2'b00);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    send_tile(8, 8'h20, 1'b1);
    idle_in();
    check("pre_latency_after_reset", 128'(s_out_valid), 128'(0));
    recv_tile(8, 8'h20, 1, 0, 15, 1'b1, 1'b0, f7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/skew_stream_buffer.md
Name: skew_stream_buffer

Overview:
- Double-buffered, parametrised operand skewer for the systolic array edge.
- Accepts a tile of up to MAX_LEN row-vectors, LANES elements each, through a valid/ready stream.
- Replays the tile with lane l delayed by l*SKEW_STEP beats; zero is driven outside each lane's active window.
- Generalises the fixed-depth per-column FIFO skew. Adds runtime tile length, output backpressure, ping-pong banks and programmable skew step.

Parameters:
BITS, 8, element width (signed)
LANES, 8, number of lanes/array columns
MAX_LEN, 16, maximum rows per tile (>=1)
SKEW_STEP, 1, extra delay per lane in beats (0 = no skew)

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-low
in_valid  in  1  input row valid
in_ready  out  1  buffer can accept row
in_data  in  BITS x LANES  signed row, one element per lane
in_last  in  1  final row of tile
out_valid  out  1  skewed beat valid
out_ready  in  1  consumer accepts beat
out_data  out  BITS x LANES  signed skewed beat
out_lane_valid  out  LANES  per-lane element-is-real flag
busy  out  1  a tile is streaming
done  out  1  one-cycle pulse after final beat of a tile accepted

Behaviour:
- Reset state:
  - All outputs 0, except in_ready=1.
  - Both banks empty; write bank=0, read bank=0; counters 0.
- Storage: two banks, each MAX_LEN x LANES x BITS, plus a length register and full flag per bank.
- Write side:
  - Row accepted on in_valid&&in_ready; stored at wr_ptr in the write bank; wr_ptr increments.
  - in_ready = !full[write bank]. It is registered-state only and not combinational on out_ready.
  - Acceptance with in_last, or acceptance at wr_ptr==MAX_LEN-1 (forced last): length <= wr_ptr+1, full set, write bank toggles, wr_ptr <= 0.
  - When both banks are full, in_ready=0.
- Read FSM, states IDLE and STREAM:
  - IDLE -> STREAM when full[read bank]. Beat counter t <= 0.
  - First out_valid occurs the cycle after the full flag sets. Minimum latency is 1 cycle from the accepting edge of the last row.
  - STREAM: out_valid=1, busy=1. Total beats T = len + (LANES-1)*SKEW_STEP.
  - Lane l at beat t: idx = t - l*SKEW_STEP. If 0 <= idx < len, out_data[l] = bank[idx][l] and out_lane_valid[l]=1; otherwise out_data[l]=0 and out_lane_valid[l]=0.
  - out_data and out_lane_valid are registered. They are held stable while out_valid && !out_ready.
  - t advances only on out_valid&&out_ready.
  - On acceptance of beat T-1: clear full[read bank], toggle read bank, pulse done the next cycle.
  - Next state after the final beat is STREAM if the other bank is already full (back-to-back, no bubble beyond the register stage), else IDLE.
- Simultaneous events:
  - The reader clearing full and the writer targeting that bank in the same cycle: the writer sees the cleared flag the following cycle.
  - Writing one bank while reading the other is always legal.
- Width rules:
  - Counter t width is $clog2(MAX_LEN+(LANES-1)*SKEW_STEP+1).
  - idx is computed signed, one bit wider.
  - Data is passed through unmodified, with no arithmetic on elements.
- Reset mid-operation: immediately returns to the reset state. Partial and full tiles are discarded and no done pulse is produced.
- Protocol rules:
  - in_data is ignored when in_valid=0.
  - A tile of length 0 cannot occur; in_last on the first row gives len=1.

Test Plan:
- Single tile: LANES=8, S=1, len=8, row r lane l = 16r+l. Beat t lane l must be 16(t-l)+l when 0<=t-l<8, else 0 with lane_valid=0. Check 15 beats total, then done pulse, then busy=0.
- Backpressure: same tile with out_ready toggling 1,0,0,1,... Beats must be held stable during stalls, with none skipped or duplicated, still 15 accepted beats.
- Back-to-back: tiles A (len 4) and B (len 6) sent without gaps. B is written while A streams; out_valid must stay high across the boundary; 11 beats then 13 beats; two done pulses. A third tile sent early must see in_ready=0 until A's bank frees.
- Boundaries:
  - len=1: beats 0..7 show the diagonal single element.
  - 16 rows without in_last: forced last at row 16; beat count 23.
- Reset mid-stream: assert rst_n=0 at beat 5. All outputs must read 0, in_ready=1, and no done pulse. A fresh tile afterwards must stream correctly.
- SKEW_STEP=0 build: len=3 yields exactly 3 beats with all lanes aligned. SKEW_STEP=2 build: lane 7 is first valid at beat 14.
